// File: rtl/vcu_pkg.sv
// Shared VCU definitions: DSP supervisor state encoding and
// default millisecond timing constants.
package vcu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RESET = 2'd1,
    ST_BOOT  = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  localparam int CLK_PER_MS_DEF = 20000;
  localparam int RST_MS_DEF     = 1;
  localparam int BOOT_MS_DEF    = 100;
  localparam int STABLE_MS_DEF  = 1000;
  localparam int MAX_RETRY_DEF  = 3;

endpackage

// File: rtl/dsp_rst_sequencer_if.sv
// DSP recovery sequencer signal bundle: fault/heartbeat/host
// inputs and reset/status outputs.
interface dsp_rst_sequencer_if;

  logic       i_fault;
  logic       i_dsp_alive;
  logic       i_clr_lock;
  logic       o_dsp_rst_n;
  logic       o_busy;
  logic       o_lockout;
  logic [3:0] o_retry_cnt;
  logic [1:0] o_state;

  modport master (
    input  i_fault,
    input  i_dsp_alive,
    input  i_clr_lock,
    output o_dsp_rst_n,
    output o_busy,
    output o_lockout,
    output o_retry_cnt,
    output o_state
  );

  modport slave (
    output i_fault,
    output i_dsp_alive,
    output i_clr_lock,
    input  o_dsp_rst_n,
    input  o_busy,
    input  o_lockout,
    input  o_retry_cnt,
    input  o_state
  );

endinterface

// File: rtl/dsp_rst_sequencer_tick.sv
// Millisecond tick prescaler; tick on terminal count, restartable
// so a dwell of N ms is exactly N*CLK_PER_MS cycles.
module ms_tick_gen
  import vcu_pkg::*;
#(
  parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
  input  logic clk_20M,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_MS - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (i_restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/dsp_rst_sequencer.sv
// DSP recovery sequencer: timed DSP reset, boot heartbeat wait,
// retry counting and latched lockout.
module dsp_rst_sequencer
  import vcu_pkg::*;
#(
  parameter int CLK_PER_MS = CLK_PER_MS_DEF,
  parameter int RST_MS     = RST_MS_DEF,
  parameter int BOOT_MS    = BOOT_MS_DEF,
  parameter int STABLE_MS  = STABLE_MS_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic                 clk_20M,
  input  logic                 reset_n,
  dsp_rst_sequencer_if.master  bus
);

  state_t      state;
  logic [15:0] ms_cnt;
  logic [15:0] ms_nxt;
  logic [3:0]  retry;
  logic        tick;
  logic        rst_done;
  logic        boot_to;
  logic        stable;
  logic        fail;
  logic        can_retry;
  logic        leave;

  assign ms_nxt    = ms_cnt + 16'd1;
  assign rst_done  = tick && (ms_nxt == 16'(RST_MS));
  assign boot_to   = tick && (ms_nxt == 16'(BOOT_MS));
  assign stable    = tick && (ms_nxt == 16'(STABLE_MS));
  assign can_retry = (retry < 4'(MAX_RETRY));

  // heartbeat beats a coincident boot timeout
  assign fail =
    (state == ST_BOOT && !bus.i_dsp_alive && boot_to) ||
    (state == ST_RUN  && bus.i_fault);

  assign leave =
    (state == ST_RESET && rst_done) ||
    (state == ST_BOOT  && (bus.i_dsp_alive || boot_to)) ||
    (state == ST_RUN   && bus.i_fault) ||
    (state == ST_LOCK  && bus.i_clr_lock);

  ms_tick_gen #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_tick (
    .clk_20M   (clk_20M),
    .reset_n   (reset_n),
    .i_restart (leave),
    .o_tick    (tick)
  );

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_RESET;
      ms_cnt          <= '0;
      retry           <= '0;
      bus.o_dsp_rst_n <= 1'b0;
      bus.o_busy      <= 1'b1;
      bus.o_lockout   <= 1'b0;
    end else begin
      if (leave) begin
        ms_cnt <= '0;
      end else if (tick) begin
        ms_cnt <= ms_nxt;
      end
      if (fail && can_retry) begin
        state           <= ST_RESET;
        retry           <= retry + 4'd1;
        bus.o_dsp_rst_n <= 1'b0;
        bus.o_busy      <= 1'b1;
      end else if (fail) begin
        state           <= ST_LOCK;
        bus.o_dsp_rst_n <= 1'b0;
        bus.o_busy      <= 1'b0;
        bus.o_lockout   <= 1'b1;
      end else begin
        unique case (state)
          ST_RESET: begin
            if (rst_done) begin
              state           <= ST_BOOT;
              bus.o_dsp_rst_n <= 1'b1;
            end
          end
          ST_BOOT: begin
            if (bus.i_dsp_alive) begin
              state      <= ST_RUN;
              bus.o_busy <= 1'b0;
            end
          end
          ST_RUN: begin
            // fault-free window elapsed: forgive past retries
            if (stable) begin
              retry  <= '0;
              ms_cnt <= '0;
            end
          end
          ST_LOCK: begin
            if (bus.i_clr_lock) begin
              state         <= ST_RESET;
              retry         <= '0;
              bus.o_busy    <= 1'b1;
              bus.o_lockout <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.o_state     = state;
  assign bus.o_retry_cnt = retry;

endmodule

// File: tb/tb_dsp_rst_sequencer.sv
// Directed bench for dsp_rst_sequencer with shortened timing.
module tb_dsp_rst_sequencer;

  localparam int CPM  = 10;
  localparam int RSTM = 2;
  localparam int BOTM = 5;
  localparam int STBM = 8;
  localparam int MAXR = 2;

  logic clk_20M = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   n;

  dsp_rst_sequencer_if bus ();

  dsp_rst_sequencer #(
    .CLK_PER_MS (CPM),
    .RST_MS     (RSTM),
    .BOOT_MS    (BOTM),
    .STABLE_MS  (STBM),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk_20M (clk_20M),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #25 clk_20M = ~clk_20M;

  task automatic step(input int k);
    repeat (k) @(posedge clk_20M);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic low_len(output int k);
    k = 0;
    while (bus.o_dsp_rst_n === 1'b0 && k < 300) begin
      k++;
      step(1);
    end
  endtask

  task automatic boot_len(output int k);
    k = 0;
    while (bus.o_state === 2'd2 && k < 300) begin
      k++;
      step(1);
    end
  endtask

  task automatic pulse_alive();
    bus.i_dsp_alive = 1'b1;
    step(1);
    bus.i_dsp_alive = 1'b0;
  endtask

  task automatic pulse_fault();
    bus.i_fault = 1'b1;
    step(1);
    bus.i_fault = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.i_clr_lock = 1'b1;
    step(1);
    bus.i_clr_lock = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.i_fault     = 1'b0;
    bus.i_dsp_alive = 1'b0;
    bus.i_clr_lock  = 1'b0;
    step(3);
    chk("rst_state", 16'(bus.o_state), 16'd1);
    chk("rst_dsp_n", 16'(bus.o_dsp_rst_n), 16'd0);
    chk("rst_busy", 16'(bus.o_busy), 16'd1);
    chk("rst_lock", 16'(bus.o_lockout), 16'd0);
    chk("rst_retry", 16'(bus.o_retry_cnt), 16'd0);
    reset_n = 1'b1;

    // power-on pulse and first boot
    low_len(n);
    chk("po_low_len", 16'(n), 16'd20);
    chk("po_boot", 16'(bus.o_state), 16'd2);
    step(5);
    pulse_alive();
    chk("po_run", 16'(bus.o_state), 16'd0);
    chk("po_retry", 16'(bus.o_retry_cnt), 16'd0);
    chk("po_busy", 16'(bus.o_busy), 16'd0);

    // fault in RUN
    pulse_fault();
    chk("f_state", 16'(bus.o_state), 16'd1);
    chk("f_retry", 16'(bus.o_retry_cnt), 16'd1);
    low_len(n);
    chk("f_low_len", 16'(n), 16'd20);
    step(3);
    pulse_alive();
    chk("f_run", 16'(bus.o_state), 16'd0);

    // stable window clears retry on 8th tick
    step(79);
    chk("stb_before", 16'(bus.o_retry_cnt), 16'd1);
    step(1);
    chk("stb_after", 16'(bus.o_retry_cnt), 16'd0);
    chk("stb_state", 16'(bus.o_state), 16'd0);

    // boot timeouts with fault held through RESET/BOOT
    bus.i_fault = 1'b1;
    step(1);
    chk("to_state", 16'(bus.o_state), 16'd1);
    chk("to_retry1", 16'(bus.o_retry_cnt), 16'd1);
    low_len(n);
    chk("to_low_len", 16'(n), 16'd20);
    boot_len(n);
    chk("to_boot_len", 16'(n), 16'd50);
    chk("to_reset", 16'(bus.o_state), 16'd1);
    chk("to_retry2", 16'(bus.o_retry_cnt), 16'd2);
    bus.i_fault = 1'b0;
    low_len(n);
    chk("to_low_len2", 16'(n), 16'd20);
    boot_len(n);
    chk("to_boot_len2", 16'(n), 16'd50);
    chk("lk_state", 16'(bus.o_state), 16'd3);
    chk("lk_lockout", 16'(bus.o_lockout), 16'd1);
    chk("lk_retry", 16'(bus.o_retry_cnt), 16'd2);
    chk("lk_dsp_n", 16'(bus.o_dsp_rst_n), 16'd0);
    chk("lk_busy", 16'(bus.o_busy), 16'd0);

    // lock clear
    pulse_fault();
    chk("lk_ign_fault", 16'(bus.o_state), 16'd3);
    pulse_clr();
    chk("clr_state", 16'(bus.o_state), 16'd1);
    chk("clr_retry", 16'(bus.o_retry_cnt), 16'd0);
    chk("clr_lockout", 16'(bus.o_lockout), 16'd0);
    chk("clr_busy", 16'(bus.o_busy), 16'd1);
    low_len(n);
    chk("clr_low_len", 16'(n), 16'd20);
    pulse_alive();
    chk("clr_run", 16'(bus.o_state), 16'd0);
    pulse_clr();
    chk("clr_run_state", 16'(bus.o_state), 16'd0);
    chk("clr_run_dsp_n", 16'(bus.o_dsp_rst_n), 16'd1);

    // alive ignored in RESET; alive + timeout same cycle
    pulse_fault();
    chk("c_retry1", 16'(bus.o_retry_cnt), 16'd1);
    pulse_alive();
    chk("c_reset_ign", 16'(bus.o_state), 16'd1);
    low_len(n);
    chk("c_low_len", 16'(n), 16'd19);
    step(49);
    chk("c_b49", 16'(bus.o_state), 16'd2);
    pulse_alive();
    chk("c_alive_wins", 16'(bus.o_state), 16'd0);
    chk("c_retry_keep", 16'(bus.o_retry_cnt), 16'd1);

    // async reset mid-BOOT
    pulse_fault();
    chk("ar_retry2", 16'(bus.o_retry_cnt), 16'd2);
    low_len(n);
    step(10);
    chk("ar_boot", 16'(bus.o_dsp_rst_n), 16'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_dsp_n", 16'(bus.o_dsp_rst_n), 16'd0);
    chk("ar_retry", 16'(bus.o_retry_cnt), 16'd0);
    chk("ar_state", 16'(bus.o_state), 16'd1);
    chk("ar_busy", 16'(bus.o_busy), 16'd1);
    step(2);
    reset_n = 1'b1;
    low_len(n);
    chk("ar_low_len", 16'(n), 16'd20);
    chk("ar_boot2", 16'(bus.o_state), 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
